stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Controller and arbiter for the CPU's 1024×32 hardware stack. It shares the single push/pop port between the CPU execute stage and the interrupt context engine, which performs multi-word save and restore bursts. It tracks stack depth, refuses overflowing and underflowing operations, and drives the stack's synchronous reset. It sits between the requesters and the stack instance.

## Interface
- DEPTH, 1024: stack capacity in words; the depth counter is clog2(DEPTH)+1 bits wide.
- CNT_W, 5: width of the burst count and burst index; maximum burst is 2^CNT_W−1 words.
- clk  in  1  system clock.
- reset  in  1  **asynchronous, active-low** reset.
- cpu_req  in  1  CPU request, level; held until cpu_ack.
- cpu_op  in  1  0 = push, 1 = pop.
- cpu_wdata  in  32  push data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  pop data, valid with cpu_ack.
- cpu_err  out  1  with cpu_ack: the operation was refused.
- irq_save / irq_restore  in  1  burst requests, level; held until irq_done.
- irq_count  in  CNT_W  burst length N, sampled at start.
- irq_idx  out  CNT_W  word index currently addressed.
- irq_wdata  in  32  word for irq_idx; the requester supplies it combinationally.
- irq_rdata  out  32  restored word; irq_rvalid  out  1  marks it valid.
- irq_busy  out  1  a burst is in progress.
- irq_done  out  1  one-cycle burst-complete pulse.
- irq_err  out  1  with irq_done: the burst was refused.
- stk_d  out  32, stk_push  out  1, stk_pop  out  1, stk_q  in  32, stk_rst  out  1: stack port. Pop data appears on stk_q one cycle after stk_pop.
- depth  out  11, full  out  1, empty  out  1: occupancy.
- ovf_err / unf_err  out  1  sticky error flags; err_clr  in  1  clears them.

## Operation
- FSM states: IDLE, CPU_OP, CPU_POPW, SAVE, RESTORE, RST_LAST, DONE.
- IDLE priority: irq_save first, then irq_restore, then cpu_req. If irq_save and irq_restore are both high, the save wins. Requests are sampled only in IDLE.
- CPU push, legal:
  - IDLE→CPU_OP; in CPU_OP: stk_push=1, stk_d=captured cpu_wdata, cpu_ack=1.
  - CPU_OP→IDLE.
- CPU pop, legal:
  - IDLE→CPU_OP with stk_pop=1.
  - CPU_OP→CPU_POPW: cpu_ack=1, cpu_rdata=stk_q.
  - CPU_POPW→IDLE.
- CPU illegal request (push with full=1, or pop with empty=1):
  - CPU_OP issues no strobe; cpu_ack=1, cpu_err=1, cpu_rdata=0.
  - Sets ovf_err (push) or unf_err (pop).
- Save, N words:
  - Legal if depth+N≤DEPTH. SAVE lasts N cycles, k=0..N−1: irq_idx=k, stk_push=1, stk_d=irq_wdata.
  - Then DONE: irq_done=1.
- Restore, N words:
  - Legal if depth≥N. RESTORE lasts N cycles with stk_pop=1.
  - irq_rvalid follows one cycle later for each pop; irq_rdata=stk_q; irq_idx counts N−1 down to 0, so words return to their original index.
  - The last rvalid occurs in RST_LAST, together with irq_done=1.
- Refused burst: IDLE→DONE with irq_done=1, irq_err=1, no strobes; sets ovf_err (save) or unf_err (restore).
- N=0: IDLE→DONE, irq_err=0, no strobes.
- irq_busy=1 in SAVE, RESTORE, RST_LAST and DONE.
- Depth counter: +1 on each stk_push, −1 on each stk_pop; never both in the same cycle. full = (depth==DEPTH), empty = (depth==0).
- err_clr clears ovf_err/unf_err. If err_clr and a new error occur in the same cycle, the set wins.

## Timing
- Reset values (reset low):
  - State IDLE; depth=0.
  - All acks, strobes, flags, irq_idx and rdata are 0.
  - stk_rst=1, which asynchronously forces the stack's reset.
- stk_rst deasserts on the first clk edge after reset rises; stk_push and stk_pop stay 0 while stk_rst=1.
- Reset mid-burst aborts the burst: no irq_done, depth=0, and the stack pointer is cleared through stk_rst.
- Latency:
  - Push: cpu_ack 1 cycle after cpu_req is sampled.
  - Pop: cpu_ack 2 cycles after cpu_req is sampled.
  - Save: irq_done N+1 cycles after start.
  - Restore: irq_done N+1 cycles after start.
- Requesters must drop their request in the ack/done cycle. A request still high on return to IDLE is treated as a new request.
- A CPU request arriving during a burst waits, at most N+2 cycles.

## Configuration
- STACK_CTRL_GUARD_EN defined: full/empty/burst-fit checks and the error behaviour are as above.
- STACK_CTRL_GUARD_EN undefined:
  - No refusals: every operation strobes the stack.
  - cpu_err, irq_err, ovf_err and unf_err are tied to 0.
  - depth wraps modulo 2^11.
  - full and empty are still reported.

## Test plan
- Reset held low 3 cycles, then released: stk_rst=1 until the first edge after release; depth=0, empty=1, all outputs 0.
- CPU push 0xDEADBEEF, then pop: push ack 1 cycle after req; pop ack 2 cycles after req with cpu_rdata=0xDEADBEEF; depth goes 1→0.
- Save N=4 (word k = 0x100+k), then restore N=4: irq_rvalid idx 3,2,1,0 with data 0x103..0x100; irq_done after 5 cycles for each burst; depth 4→0.
- Pop at empty: cpu_ack, cpu_err=1, unf_err=1, no stk_pop. err_clr pulse → unf_err=0.
- Fill to 1020 words, then save N=5: refused with irq_err=1, ovf_err=1, depth stays 1020. Save N=4 → full=1.
- cpu_req raised in the same cycle as irq_save (N=3): the save runs first and cpu_ack arrives only after irq_done. Reset asserted mid-restore: no irq_done, depth=0.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Requester-side bundle for stack_ctrl: CPU push/pop handshake plus the IRQ save/restore burst port.
interface stack_ctrl_if #(
  parameter int CNT_W = 5,
  parameter int DW    = 32
);
  logic             cpu_req;
  logic             cpu_op;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_ack;
  logic             cpu_err;
  logic [DW-1:0]    cpu_rdata;
  logic             irq_save;
  logic             irq_restore;
  logic [CNT_W-1:0] irq_count;
  logic [CNT_W-1:0] irq_idx;
  logic [DW-1:0]    irq_wdata;
  logic [DW-1:0]    irq_rdata;
  logic             irq_rvalid;
  logic             irq_busy;
  logic             irq_done;
  logic             irq_err;

  modport slave (
    input  cpu_req, cpu_op, cpu_wdata, irq_save, irq_restore, irq_count, irq_wdata,
    output cpu_ack, cpu_err, cpu_rdata, irq_idx, irq_rdata, irq_rvalid, irq_busy, irq_done, irq_err
  );
  modport master (
    output cpu_req, cpu_op, cpu_wdata, irq_save, irq_restore, irq_count, irq_wdata,
    input  cpu_ack, cpu_err, cpu_rdata, irq_idx, irq_rdata, irq_rvalid, irq_busy, irq_done, irq_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Arbitrates the single stack push/pop port between CPU ops and IRQ save/restore bursts, tracking depth.
// Macro STACK_CTRL_GUARD_EN enables overflow/underflow refusal and the sticky error flags.
module stack_ctrl #(
  parameter int  DEPTH = 1024,
  parameter int  CNT_W = 5,
  parameter int  DW    = 32,
  localparam int DEP_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  stack_ctrl_if.slave      bus,
  output logic [DW-1:0]    stk_d,
  output logic             stk_push,
  output logic             stk_pop,
  input  logic [DW-1:0]    stk_q,
  output logic             stk_rst,
  output logic [DEP_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  input  logic             err_clr
);
  typedef enum logic [2:0] {IDLE, CPU_OP, CPU_POPW, SAVE, RESTORE, RST_LAST, DONE} state_e;

  state_e           state_q, state_d;
  logic [DEP_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0] cnt_q, idx_q;
  logic [DW-1:0]    wdata_q;
  logic             op_q, err_q, rvalid_q, rst_q, ovf_q, ovf_d, unf_q, unf_d;
  logic             push_c, pop_c, save_bad, rest_bad, cpu_bad, n_zero, set_ovf, set_unf;

  assign depth   = depth_q;
  assign full    = (depth_q == DEP_W'(DEPTH));
  assign empty   = (depth_q == '0);
  assign stk_rst = rst_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
  assign n_zero  = (bus.irq_count == '0);

`ifdef STACK_CTRL_GUARD_EN
  logic [DEP_W:0] fit_sum;
  assign fit_sum  = {1'b0, depth_q} + (DEP_W+1)'(bus.irq_count);
  assign save_bad = (fit_sum > (DEP_W+1)'(DEPTH));
  assign rest_bad = (depth_q < DEP_W'(bus.irq_count));
  assign cpu_bad  = bus.cpu_op ? empty : full;
`else
  assign save_bad = 1'b0;
  assign rest_bad = 1'b0;
  assign cpu_bad  = 1'b0;
`endif

  // Burst refusals latch at the IDLE decision; CPU refusals latch as CPU_OP retires.
  assign set_ovf = (state_q == IDLE && bus.irq_save && save_bad) ||
                   (state_q == CPU_OP && err_q && !op_q);
  assign set_unf = (state_q == IDLE && !bus.irq_save && bus.irq_restore && rest_bad) ||
                   (state_q == CPU_OP && err_q && op_q);
  assign ovf_d   = set_ovf | (ovf_q & ~err_clr);
  assign unf_d   = set_unf | (unf_q & ~err_clr);
  assign depth_d = stk_push ? depth_q + DEP_W'(1) :
                   stk_pop  ? depth_q - DEP_W'(1) : depth_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.irq_save)         state_d = (n_zero || save_bad) ? DONE : SAVE;
        else if (bus.irq_restore) state_d = (n_zero || rest_bad) ? DONE : RESTORE;
        else if (bus.cpu_req)     state_d = CPU_OP;
      end
      CPU_OP:   state_d = (op_q && !err_q) ? CPU_POPW : IDLE;
      CPU_POPW: state_d = IDLE;
      SAVE:     if (idx_q == cnt_q - CNT_W'(1)) state_d = DONE;
      RESTORE:  if (idx_q == CNT_W'(1)) state_d = RST_LAST;
      RST_LAST: state_d = IDLE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    push_c          = 1'b0;
    pop_c           = 1'b0;
    stk_d           = '0;
    bus.cpu_ack     = 1'b0;
    bus.cpu_err     = 1'b0;
    bus.cpu_rdata   = '0;
    bus.irq_idx     = '0;
    bus.irq_rdata   = '0;
    bus.irq_rvalid  = 1'b0;
    bus.irq_busy    = 1'b0;
    bus.irq_done    = 1'b0;
    bus.irq_err     = 1'b0;
    unique case (state_q)
      CPU_OP: begin
        push_c      = !op_q && !err_q;
        pop_c       = op_q && !err_q;
        if (!op_q) stk_d = wdata_q;
        bus.cpu_ack = !op_q || err_q;
        bus.cpu_err = err_q;
      end
      CPU_POPW: begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_rdata = stk_q;
      end
      SAVE: begin
        push_c       = 1'b1;
        stk_d        = bus.irq_wdata;
        bus.irq_idx  = idx_q;
        bus.irq_busy = 1'b1;
      end
      RESTORE: begin
        // idx_q runs one ahead (starts at N) so it labels the word popped last cycle.
        pop_c          = 1'b1;
        bus.irq_busy   = 1'b1;
        bus.irq_rvalid = rvalid_q;
        if (rvalid_q) begin
          bus.irq_idx   = idx_q;
          bus.irq_rdata = stk_q;
        end
      end
      RST_LAST: begin
        bus.irq_busy   = 1'b1;
        bus.irq_done   = 1'b1;
        bus.irq_rvalid = 1'b1;
        bus.irq_idx    = idx_q;
        bus.irq_rdata  = stk_q;
      end
      DONE: begin
        bus.irq_busy = 1'b1;
        bus.irq_done = 1'b1;
        bus.irq_err  = err_q;
      end
      default: ;
    endcase
  end

  assign stk_push = push_c & ~rst_q;
  assign stk_pop  = pop_c & ~rst_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rst_q    <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rst_q    <= 1'b0;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= (state_q == RESTORE);
      if (state_q == IDLE) begin
        cnt_q   <= bus.irq_count;
        op_q    <= bus.cpu_op;
        wdata_q <= bus.cpu_wdata;
        err_q   <= bus.irq_save ? save_bad : bus.irq_restore ? rest_bad : cpu_bad;
        idx_q   <= bus.irq_save ? '0 : bus.irq_count;
      end else if (state_q == SAVE) begin
        idx_q <= idx_q + CNT_W'(1);
      end else if (state_q == RESTORE) begin
        idx_q <= idx_q - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack device plus a queue-based occupancy/data model.
module tb_stack_ctrl;
  localparam int DEPTH = 1024;
  localparam int CNT_W = 5;
  localparam int DW    = 32;
`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        err_clr = 1'b0;
  logic [31:0] stk_d, stk_q = '0;
  logic        stk_push, stk_pop, stk_rst, full, empty, ovf_err, unf_err;
  logic [10:0] depth;

  always #5 clk = ~clk;

  stack_ctrl_if #(.CNT_W(CNT_W), .DW(DW)) sif ();

  stack_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(sif), .stk_d(stk_d), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_q(stk_q), .stk_rst(stk_rst), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
  );

  logic [31:0] wtbl [0:31];
  assign sif.irq_wdata = wtbl[sif.irq_idx];

  // Stack device: synchronous pop data, cleared by stk_rst.
  logic [31:0] mem [$];
  int push_cnt = 0, pop_cnt = 0, both_cnt = 0;
  always @(posedge clk or posedge stk_rst) begin
    if (stk_rst) mem.delete();
    else begin
      if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
      if (stk_push) begin mem.push_back(stk_d); push_cnt <= push_cnt + 1; end
      if (stk_pop) begin
        pop_cnt <= pop_cnt + 1;
        stk_q   <= (mem.size() > 0) ? mem.pop_back() : 32'hBAD0BAD0;
      end
    end
  end

  int errors = 0, checks = 0;
  int m_depth = 0;
  bit m_ovf = 0, m_unf = 0;
  logic [31:0] m_stk [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag);
    chk({tag, "/depth"}, depth, m_depth);
    chk({tag, "/full"}, full, m_depth == DEPTH);
    chk({tag, "/empty"}, empty, m_depth == 0);
    chk({tag, "/ovf"}, ovf_err, m_ovf);
    chk({tag, "/unf"}, unf_err, m_unf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    sif.cpu_req = 0; sif.irq_save = 0; sif.irq_restore = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst/stk_rst", stk_rst, 1);
    chk("rst/depth", depth, 0);
    chk("rst/empty", empty, 1);
    chk("rst/outs", {stk_push, stk_pop, sif.cpu_ack, sif.cpu_err, sif.irq_busy, sif.irq_done,
                     sif.irq_err, sif.irq_rvalid, ovf_err, unf_err, full}, 0);
    chk("rst/data", sif.cpu_rdata | sif.irq_rdata | 32'(sif.irq_idx), 0);
    reset = 1'b1;
    #1 chk("rst/stk_rst_hold", stk_rst, 1);
    @(negedge clk);
    chk("rst/stk_rst_drop", stk_rst, 0);
    m_depth = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
  endtask

  task automatic clr_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_ovf = 0; m_unf = 0;
    chk("clr/flags", {ovf_err, unf_err}, 0);
  endtask

  task automatic do_cpu(input bit pop, input logic [31:0] wd, input string tag);
    bit bad; int lat, s0; logic [31:0] rd, exp_rd; logic er;
    bad = GUARD && (pop ? (m_depth == 0) : (m_depth == DEPTH));
    s0 = push_cnt + pop_cnt;
    @(negedge clk);
    sif.cpu_req = 1'b1; sif.cpu_op = pop; sif.cpu_wdata = wd;
    lat = 0; rd = 'x; er = 1'bx;
    repeat (50) begin
      @(negedge clk); lat++;
      if (sif.cpu_ack === 1'b1) begin rd = sif.cpu_rdata; er = sif.cpu_err; break; end
    end
    sif.cpu_req = 1'b0;
    exp_rd = '0;
    if (!bad && pop) exp_rd = (m_stk.size() > 0) ? m_stk.pop_back() : 32'hBAD0BAD0;
    if (!bad && !pop) m_stk.push_back(wd);
    if (!bad) m_depth = (m_depth + (pop ? -1 : 1)) & 2047;
    if (bad && pop) m_unf = 1;
    if (bad && !pop) m_ovf = 1;
    @(negedge clk);
    chk({tag, "/lat"}, lat, bad ? 1 : (pop ? 2 : 1));
    chk({tag, "/err"}, er, bad);
    chk({tag, "/rdata"}, rd, exp_rd);
    chk({tag, "/strobes"}, push_cnt + pop_cnt - s0, bad ? 0 : 1);
    chk_occ(tag);
  endtask

  task automatic do_burst(input bit rest, input int n, input bit use_base, input logic [31:0] base,
                          input string tag);
    bit bad; int lat, nrv, busy, s0; logic er;
    logic [31:0] gdat [0:31]; int gidx [0:31];
    bad = GUARD && (rest ? (m_depth < n) : (m_depth + n > DEPTH));
    if (!rest) for (int k = 0; k < n; k++) wtbl[k] = use_base ? base + 32'(k) : $urandom;
    s0 = push_cnt + pop_cnt;
    @(negedge clk);
    sif.irq_save = !rest; sif.irq_restore = rest; sif.irq_count = CNT_W'(n);
    lat = 0; nrv = 0; busy = 0; er = 1'bx;
    repeat (60) begin
      @(negedge clk); lat++;
      if (sif.irq_busy === 1'b1) busy++;
      if (sif.irq_rvalid === 1'b1 && nrv < 32) begin
        gdat[nrv] = sif.irq_rdata; gidx[nrv] = int'(sif.irq_idx); nrv++;
      end
      if (sif.irq_done === 1'b1) begin er = sif.irq_err; break; end
    end
    sif.irq_save = 0; sif.irq_restore = 0;
    chk({tag, "/lat"}, lat, (bad || n == 0) ? 1 : n + 1);
    chk({tag, "/busy"}, busy, (bad || n == 0) ? 1 : n + 1);
    chk({tag, "/err"}, er, bad);
    chk({tag, "/nrv"}, nrv, (rest && !bad) ? n : 0);
    for (int k = 0; k < nrv; k++) begin
      chk({tag, "/ridx"}, gidx[k], n - 1 - k);
      chk({tag, "/rdata"}, gdat[k], (m_stk.size() > 0) ? m_stk.pop_back() : 32'hBAD0BAD0);
    end
    if (!bad && !rest) for (int k = 0; k < n; k++) m_stk.push_back(wtbl[k]);
    if (!bad) m_depth = (m_depth + (rest ? -n : n)) & 2047;
    if (bad && rest) m_unf = 1;
    if (bad && !rest) m_ovf = 1;
    @(negedge clk);
    chk({tag, "/strobes"}, push_cnt + pop_cnt - s0, bad ? 0 : n);
    chk_occ(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_c, ack_c, rem, dseen;
    logic [31:0] w;
    sif.cpu_req = 0; sif.cpu_op = 0; sif.cpu_wdata = 0;
    sif.irq_save = 0; sif.irq_restore = 0; sif.irq_count = 0;
    for (int k = 0; k < 32; k++) wtbl[k] = 0;
    do_reset();

    do_cpu(1'b0, 32'hDEADBEEF, "push1");
    do_cpu(1'b1, 32'h0, "pop1");
    do_burst(1'b0, 4, 1'b1, 32'h100, "save4");
    do_burst(1'b1, 4, 1'b0, 32'h0, "rest4");
    do_burst(1'b0, 0, 1'b0, 32'h0, "save0");

    // CPU request raised together with a save: save first, push after irq_done.
    for (int k = 0; k < 3; k++) wtbl[k] = $urandom;
    w = $urandom;
    @(negedge clk);
    sif.irq_save = 1; sif.irq_count = 3; sif.cpu_req = 1; sif.cpu_op = 0; sif.cpu_wdata = w;
    done_c = 0; ack_c = 0;
    for (int c = 1; c <= 40 && (done_c == 0 || ack_c == 0); c++) begin
      @(negedge clk);
      if (sif.irq_done === 1'b1 && done_c == 0) begin done_c = c; sif.irq_save = 0; end
      if (sif.cpu_ack === 1'b1 && ack_c == 0) begin ack_c = c; sif.cpu_req = 0; end
    end
    sif.irq_save = 0; sif.cpu_req = 0;
    for (int k = 0; k < 3; k++) m_stk.push_back(wtbl[k]);
    m_stk.push_back(w);
    m_depth += 4;
    @(negedge clk);
    chk("conc/done_lat", done_c, 4);
    chk("conc/ack_after_done", ack_c > done_c, 1);
    chk("conc/ack_wait", ack_c > 0 && ack_c <= done_c + 2, 1);
    chk_occ("conc");
    do_cpu(1'b1, 32'h0, "conc_pop");
    do_burst(1'b1, 3, 1'b0, 32'h0, "conc_rest");

    do_cpu(1'b1, 32'h0, "pop_empty");
    clr_err();

    while (m_depth != 1020) begin
      rem = (1020 - m_depth) & 2047;
      do_burst(1'b0, rem > 31 ? 31 : rem, 1'b0, 32'h0, "fill");
    end
    do_burst(1'b0, 5, 1'b0, 32'h0, "save5_over");
    while (m_depth > 1020 && m_depth < 1100) do_burst(1'b1, m_depth - 1020, 1'b0, 32'h0, "trim");
    clr_err();
    do_burst(1'b0, 4, 1'b0, 32'h0, "save4_full");
    chk("full@1024", full, 1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: do_cpu(1'b0, $urandom, "rnd_push");
        1: do_cpu(1'b1, 32'h0, "rnd_pop");
        2: do_burst(1'b0, $urandom_range(0, 6), 1'b0, 32'h0, "rnd_save");
        default: do_burst(1'b1, $urandom_range(0, 6), 1'b0, 32'h0, "rnd_rest");
      endcase
    end

    // Reset in the middle of a restore burst.
    do_reset();
    do_burst(1'b0, 8, 1'b0, 32'h0, "pre_abort");
    @(negedge clk);
    sif.irq_restore = 1; sif.irq_count = 8;
    dseen = 0;
    repeat (3) begin @(negedge clk); if (sif.irq_done === 1'b1) dseen++; end
    reset = 1'b0;
    #1;
    chk("abort/depth", depth, 0);
    chk("abort/stk_rst", stk_rst, 1);
    chk("abort/busy", sif.irq_busy, 0);
    sif.irq_restore = 0;
    repeat (2) begin @(negedge clk); if (sif.irq_done === 1'b1) dseen++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (sif.irq_done === 1'b1) dseen++; end
    chk("abort/no_done", dseen, 0);
    m_depth = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
    chk_occ("abort");
    do_cpu(1'b0, 32'h5A5A0001, "post_push");
    do_cpu(1'b1, 32'h0, "post_pop");
    chk("strobe_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
